// File: rtl/vga_ctrl_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : vga_ctrl_unit
//  Brief    : 400x320 VGA timing generator with 128-bit RGB565 word unpacker
//  Revision : 1.0 - initial release
// ============================================================================
module vga_ctrl_unit #(
    parameter int USER_DATA_WIDTH = 128,
    parameter int H_SYNC          = 10,
    parameter int H_BACK          = 25,
    parameter int H_VALID         = 400,
    parameter int H_FRONT         = 20,
    parameter int H_TOTAL         = H_SYNC + H_BACK + H_VALID + H_FRONT,
    parameter int V_SYNC          = 9,
    parameter int V_BACK          = 20,
    parameter int V_VALID         = 320,
    parameter int V_FRONT         = 16,
    parameter int V_TOTAL         = V_SYNC + V_BACK + V_VALID + V_FRONT
) (
    input  logic                       clk,
    input  logic                       sys_rst,
    output logic                       vga_clk,
    output logic                       vga_de,
    output logic                       vga_hsync,
    output logic                       vga_vsync,
    output logic [23:0]                vga_rgb,
    output logic                       read_req,
    input  logic [USER_DATA_WIDTH-1:0] read_data,
    output logic                       cmos_vsync_begin,
    output logic                       cmos_vsync_end
);

    localparam int c_h_w = $clog2(H_TOTAL);
    localparam int c_v_w = $clog2(V_TOTAL);

    localparam logic [c_h_w-1:0] c_h_last    = c_h_w'(H_TOTAL - 1);
    localparam logic [c_h_w-1:0] c_h_sync    = c_h_w'(H_SYNC);
    localparam logic [c_h_w-1:0] c_h_act_beg = c_h_w'(H_SYNC + H_BACK);
    localparam logic [c_h_w-1:0] c_h_act_end = c_h_w'(H_SYNC + H_BACK + H_VALID);
    localparam logic [c_h_w-1:0] c_h_req_beg = c_h_w'(H_SYNC + H_BACK - 1);
    localparam logic [c_h_w-1:0] c_h_req_end = c_h_w'(H_SYNC + H_BACK + H_VALID - 1);

    localparam logic [c_v_w-1:0] c_v_last    = c_v_w'(V_TOTAL - 1);
    localparam logic [c_v_w-1:0] c_v_sync    = c_v_w'(V_SYNC);
    localparam logic [c_v_w-1:0] c_v_act_beg = c_v_w'(V_SYNC + V_BACK);
    localparam logic [c_v_w-1:0] c_v_act_end = c_v_w'(V_SYNC + V_BACK + V_VALID);

    logic [c_h_w-1:0]            r_cnt_h;
    logic [c_v_w-1:0]            r_cnt_v;
    logic [2:0]                  r_pix_idx;
    logic [USER_DATA_WIDTH-17:0] r_word;

    logic       w_h_active;
    logic       w_v_active;
    logic       w_hsync;
    logic       w_vsync;
    logic [2:0] w_req_phase;
    logic       w_req;
    logic [15:0] w_pix;

    assign vga_clk = clk;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt_h <= '0;
            r_cnt_v <= '0;
        end else if (r_cnt_h == c_h_last) begin
            r_cnt_h <= '0;
            r_cnt_v <= (r_cnt_v == c_v_last) ? '0 : r_cnt_v + 1'b1;
        end else begin
            r_cnt_h <= r_cnt_h + 1'b1;
        end
    end

    assign w_h_active  = (r_cnt_h >= c_h_act_beg) && (r_cnt_h < c_h_act_end);
    assign w_v_active  = (r_cnt_v >= c_v_act_beg) && (r_cnt_v < c_v_act_end);
    assign w_hsync     = (r_cnt_h < c_h_sync);
    assign w_vsync     = (r_cnt_v < c_v_sync);

    // Request leads each 8-pixel group by one counter step so the word lands on pixel 0.
    assign w_req_phase = r_cnt_h[2:0] - c_h_req_beg[2:0];
    assign w_req       = w_v_active && (r_cnt_h >= c_h_req_beg) &&
                         (r_cnt_h < c_h_req_end) && (w_req_phase == 3'd0);

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            vga_de           <= 1'b0;
            vga_hsync        <= 1'b0;
            vga_vsync        <= 1'b0;
            read_req         <= 1'b0;
            cmos_vsync_begin <= 1'b0;
            cmos_vsync_end   <= 1'b0;
        end else begin
            vga_de           <= w_h_active & w_v_active;
            vga_hsync        <= w_hsync;
            vga_vsync        <= w_vsync;
            read_req         <= w_req;
            cmos_vsync_begin <= w_vsync & ~vga_vsync;
            cmos_vsync_end   <= ~w_vsync & vga_vsync;
        end
    end

    // Pixel 0 is consumed straight from the bus; the rest come from the captured word.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pix_idx <= 3'd0;
            r_word    <= '0;
        end else begin
            r_pix_idx <= vga_de ? r_pix_idx + 3'd1 : 3'd0;
            if (vga_de && (r_pix_idx == 3'd0)) begin
                r_word <= read_data[USER_DATA_WIDTH-1:16];
            end
        end
    end

    always_comb begin
        w_pix = read_data[15:0];
        case (r_pix_idx)
            3'd0:    w_pix = read_data[15:0];
            3'd1:    w_pix = r_word[15:0];
            3'd2:    w_pix = r_word[31:16];
            3'd3:    w_pix = r_word[47:32];
            3'd4:    w_pix = r_word[63:48];
            3'd5:    w_pix = r_word[79:64];
            3'd6:    w_pix = r_word[95:80];
            default: w_pix = r_word[111:96];
        endcase
    end

    assign vga_rgb = vga_de ? {w_pix[15:11], w_pix[15:13],
                               w_pix[10:5],  w_pix[10:9],
                               w_pix[4:0],   w_pix[4:2]} : 24'h000000;

endmodule
`default_nettype wire

// File: tb/tb_vga_ctrl_unit.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboarded bench for vga_ctrl_unit: full-size timing reference plus a
// shrunken instance whose whole frame fits in a few hundred clocks.
module tb_vga_ctrl_unit;

    localparam int HT = 455, VT = 365;
    localparam int HS = 10, HA = 35, HV = 400;
    localparam int VS = 9,  VA = 29, VV = 320;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         vga_clk, vga_de, vga_hsync, vga_vsync, read_req;
    logic         cmos_vsync_begin, cmos_vsync_end;
    logic [23:0]  vga_rgb;
    logic [127:0] read_data;

    logic         s_clk, s_de, s_hs, s_vs, s_req, s_beg, s_end;
    logic [23:0]  s_rgb;
    logic [127:0] s_rd;

    always #5 clk = ~clk;

    vga_ctrl_unit dut (
        .clk(clk), .sys_rst(rst), .vga_clk(vga_clk), .vga_de(vga_de),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_rgb(vga_rgb),
        .read_req(read_req), .read_data(read_data),
        .cmos_vsync_begin(cmos_vsync_begin), .cmos_vsync_end(cmos_vsync_end)
    );

    vga_ctrl_unit #(
        .H_SYNC(2), .H_BACK(3), .H_VALID(16), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(1), .V_VALID(3),  .V_FRONT(1)
    ) dut_small (
        .clk(clk), .sys_rst(rst), .vga_clk(s_clk), .vga_de(s_de),
        .vga_hsync(s_hs), .vga_vsync(s_vs), .vga_rgb(s_rgb),
        .read_req(s_req), .read_data(s_rd),
        .cmos_vsync_begin(s_beg), .cmos_vsync_end(s_end)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int mode;
    int wcount;
    int beg_cyc, de_cnt, req_cnt;
    int s_beg_cyc, s_de_cnt, s_req_cnt;
    bit s_have;
    logic [23:0] exp_q[$];
    logic [5:0]  ctl;

    assign ctl = {vga_de, vga_hsync, vga_vsync, read_req, cmos_vsync_begin, cmos_vsync_end};

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 20)
                $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [23:0] conv(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    // Expected {de,hs,vs,req,begin,end} after the k-th clock edge since reset release.
    function automatic logic [5:0] exp_ctl(input int k);
        int p, h, v;
        logic de, hs, vs, rq, bg, en, va;
        if (k == 0) return 6'b0;
        p  = (k - 1) % (HT * VT);
        h  = p % HT;
        v  = p / HT;
        va = (v >= VA) && (v < VA + VV);
        de = va && (h >= HA) && (h < HA + HV);
        hs = (h < HS);
        vs = (v < VS);
        rq = va && (h >= HA - 1) && (h < HA + HV - 1) && (((h - (HA - 1)) % 8) == 0);
        bg = (v == 0) && (h == 0);
        en = (v == VS) && (h == 0);
        return {de, hs, vs, rq, bg, en};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Source: answers each request with the next word and queues its expected pixels.
    initial begin
        logic [127:0] w;
        forever begin
            @(posedge clk);
            if (!rst && read_req) begin
                #1;
                if (mode == 0) begin
                    w = 128'h1234_5678_9abc_def0_1357_9bdf_2468_5678 + 128'(wcount);
                    for (int i = 0; i < 8; i++) exp_q.push_back(conv(w[16*i +: 16]));
                end else begin
                    w = 128'h07E0F800_07E0F800_07E0F800_07E0F800;
                    for (int i = 0; i < 8; i++)
                        exp_q.push_back((i % 2 == 0) ? 24'hFF0000 : 24'h00FF00);
                end
                read_data = w;
                wcount++;
            end
        end
    end

    // Monitor for the full-size instance.
    always @(negedge clk) begin
        logic [23:0] e;
        if (rst) begin
            check("reset_outputs", {ctl, vga_rgb}, 30'h0);
            de_cnt  = 0;
            req_cnt = 0;
        end else begin
            check("vga_clk", vga_clk, clk);
            check("timing", ctl, exp_ctl(cyc));
            if (vga_de) begin
                de_cnt++;
                if (exp_q.size() == 0) check("rgb_underflow", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rgb", vga_rgb, e);
                end
            end else begin
                check("rgb_blank", vga_rgb, 24'h0);
            end
            if (read_req) req_cnt++;
            if (cmos_vsync_begin) beg_cyc = cyc;
            if (cmos_vsync_end) check("vsync_span", cyc - beg_cyc, 4095);
            if (cyc == (VA + 3) * HT) begin
                check("de_count_3_lines", de_cnt, 3 * 400);
                check("req_count_3_lines", req_cnt, 3 * 50);
            end
        end
    end

    // Monitor for the small instance: 23 x 7 frame, 16 x 3 active.
    always @(negedge clk) begin
        if (rst) begin
            s_have = 0; s_de_cnt = 0; s_req_cnt = 0;
        end else begin
            check("small_clk", s_clk, clk);
            if (s_de) s_de_cnt++;
            else      check("small_rgb_blank", s_rgb, 24'h0);
            if (s_req) s_req_cnt++;
            if (s_beg) begin
                check("small_vs_at_begin", {s_hs, s_vs}, 2'b11);
                if (s_have) begin
                    check("small_frame_period", cyc - s_beg_cyc, 161);
                    check("small_de_per_frame", s_de_cnt, 48);
                    check("small_req_per_frame", s_req_cnt, 6);
                end else begin
                    check("small_first_begin", cyc, 1);
                end
                s_have = 1; s_beg_cyc = cyc; s_de_cnt = 0; s_req_cnt = 0;
            end
            if (s_end && s_have) check("small_vsync_span", cyc - s_beg_cyc, 46);
        end
    end

    initial begin
        rst = 1'b1; read_data = '0; s_rd = '0; mode = 0; wcount = 0;
        #200;
        @(negedge clk); #2 rst = 1'b0;
        repeat ((VA + 3) * HT + 250) @(posedge clk);

        // Mid-active-line asynchronous reset.
        @(negedge clk);
        check("de_before_reset", vga_de, 1'b1);
        #2 rst = 1'b1;
        #1 check("async_reset", {ctl, vga_rgb}, 30'h0);
        exp_q.delete();
        wcount = 0;
        mode = 1;
        repeat (5) @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        repeat ((VA + 3) * HT + 50) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
